// File: rtl/regfile_trace_monitor_pkg.sv
// Shared types and widths for the register-file trace monitor.
package regfile_trace_pkg;

    // Monitor control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Saturating drop counter width.
    localparam int DROP_CNT_W = 8;

    // Default field widths and the resulting trace entry width.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_TS_W       = 16;
    localparam int ENTRY_W        = DEF_TS_W + DEF_REG_ADDR_W + DEF_DATA_W;

    // Trace entry width for a given set of field widths: {ts, addr, data}.
    function automatic int entry_width(input int ts_w, input int addr_w, input int data_w);
        return ts_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/regfile_trace_monitor_if.sv
// Snooped register-file write port plus the trace drain handshake.
interface regfile_trace_monitor_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TS_W       = 16
);
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  trc_valid;
    logic                  trc_ready;
    logic [TS_W-1:0]       trc_ts;
    logic [REG_ADDR_W-1:0] trc_addr;
    logic [DATA_W-1:0]     trc_data;

    // Pipeline/consumer side: drives writes and accepts trace entries.
    modport master (
        output wr_en, wr_addr, wr_data, trc_ready,
        input  trc_valid, trc_ts, trc_addr, trc_data
    );

    // Monitor side: observes writes and presents trace entries.
    modport slave (
        input  wr_en, wr_addr, wr_data, trc_ready,
        output trc_valid, trc_ts, trc_addr, trc_data
    );
endinterface

// File: rtl/regfile_trace_monitor_trace_fifo.sv
// First-word fall-through FIFO holding trace entries; push while full
// is only accepted when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign pop_ok_s  = pop && !empty_s;
    assign push_ok_s = push && (!full_s || pop_ok_s);

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so no stale entry can reappear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !srst) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign dout  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

endmodule

// File: rtl/regfile_trace_monitor.sv
// Register-file trace monitor: shadows architectural registers and logs
// (optionally only changing) writes with a cycle timestamp during a
// bounded capture window.
module regfile_trace_monitor
    import regfile_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int MAX_CYCLES  = 50,
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  clear,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  running,
    output logic                  done,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    regfile_trace_monitor_if.slave bus
);
    localparam int EW    = entry_width(TS_W, REG_ADDR_W, DATA_W);
    localparam int NREGS = 2 ** REG_ADDR_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [TS_W-1:0]       LAST_TS  = TS_W'(MAX_CYCLES - 1);
    localparam logic [TS_W-1:0]       TS_ONE   = TS_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    state_e                  state_r;
    state_e                  state_nx_s;
    logic [TS_W-1:0]         cnt_r;
    logic [TS_W-1:0]         cnt_nx_s;
    logic [DATA_W-1:0]       shadow_r [NREGS];
    logic [DATA_W-1:0]       dbg_data_r;
    logic                    overflow_r;
    logic [DROP_CNT_W-1:0]   drop_cnt_r;
    logic                    wr_ok_s;
    logic                    capture_s;
    logic                    pop_ok_s;
    logic                    drop_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CW-1:0]           fifo_count_s;
    logic [EW-1:0]           head_s;

    // Control state and cycle counter update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {TS_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next state: clear wins, then start from IDLE, then halt/window end in RUN.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (clear) begin
            state_nx_s = IDLE;
            cnt_nx_s   = {TS_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nx_s = RUN;
                        cnt_nx_s   = {TS_W{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (halt_req || (cnt_r == LAST_TS)) begin
                        state_nx_s = HALTED;
                    end else begin
                        cnt_nx_s = cnt_r + TS_ONE;
                    end
                end
                HALTED: begin
                    state_nx_s = HALTED;
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {TS_W{1'b0}};
                end
            endcase
        end
    end

    // Capture qualification against the pre-write shadow value.
    always_comb begin
        wr_ok_s   = bus.wr_en && (bus.wr_addr != {REG_ADDR_W{1'b0}});
        capture_s = 1'b0;
        if ((state_r == RUN) && wr_ok_s && !clear) begin
            if (CHANGE_ONLY) begin
                capture_s = (bus.wr_data != shadow_r[bus.wr_addr]);
            end else begin
                capture_s = 1'b1;
            end
        end else begin
            capture_s = 1'b0;
        end
    end

    assign pop_ok_s = bus.trc_ready && !fifo_empty_s;
    assign drop_s   = capture_s && fifo_full_s && !pop_ok_s;

    // Shadow register file; r0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            shadow_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            shadow_r[bus.wr_addr] <= shadow_r[bus.wr_addr];
        end
    end

    // Registered debug read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_data_r <= {DATA_W{1'b0}};
        end else begin
            dbg_data_r <= shadow_r[dbg_addr];
        end
    end

    // Sticky overflow and saturating drop count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (clear) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .srst  (clear),
        .push  (capture_s),
        .din   ({cnt_r, bus.wr_addr, bus.wr_data}),
        .full  (fifo_full_s),
        .pop   (bus.trc_ready),
        .dout  (head_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign bus.trc_valid = (fifo_count_s != {CW{1'b0}});
    assign bus.trc_ts    = head_s[EW-1 -: TS_W];
    assign bus.trc_addr  = head_s[DATA_W +: REG_ADDR_W];
    assign bus.trc_data  = head_s[DATA_W-1:0];
    assign dbg_data      = dbg_data_r;
    assign running       = (state_r == RUN);
    assign done          = (state_r == HALTED);
    assign overflow      = overflow_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_regfile_trace_monitor.sv
// Self-checking bench: directed table, corner sequences and a randomized
// run, all compared against a queue-based reference model.
module tb_regfile_trace_monitor;
    localparam int DEPTH      = 16;
    localparam int MAX_CYCLES = 50;
    localparam bit CHANGE_ONLY = 1'b1;

    typedef struct packed {
        logic [15:0] ts;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        start, clr, halt, wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  dbg;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_ts;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_running;
        logic [31:0] e_dbg;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        clear;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        running;
    logic        done;
    logic        overflow;
    logic [7:0]  drop_cnt;

    regfile_trace_monitor_if #(.DATA_W(32), .REG_ADDR_W(5), .TS_W(16)) bus ();

    regfile_trace_monitor #(
        .DATA_W(32), .REG_ADDR_W(5), .DEPTH(DEPTH), .TS_W(16),
        .MAX_CYCLES(MAX_CYCLES), .CHANGE_ONLY(CHANGE_ONLY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .clear(clear), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .running(running), .done(done), .overflow(overflow),
        .drop_cnt(drop_cnt), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    ent_t        m_q[$];
    logic [31:0] m_shadow [32];
    int          m_state;   // 0 idle, 1 capturing, 2 halted
    int          m_cnt;
    int          m_drop;
    bit          m_ovf;
    logic [31:0] m_dbg;

    bit          collect = 1'b0;
    logic [15:0] got[$];
    vec_t        tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
        m_state = 0;
        m_cnt   = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_dbg   = 32'd0;
    endtask

    task automatic model_step();
        bit cap;
        bit wr_ok;
        wr_ok = bus.wr_en && (bus.wr_addr != 5'd0);
        cap = (m_state == 1) && wr_ok &&
              (!CHANGE_ONLY || (bus.wr_data != m_shadow[bus.wr_addr]));
        m_dbg = (dbg_addr == 5'd0) ? 32'd0 : m_shadow[dbg_addr];
        if (wr_ok) m_shadow[bus.wr_addr] = bus.wr_data;
        if (clear) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_cnt   = 0;
            m_state = 0;
        end else begin
            if (bus.trc_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_cnt[15:0], bus.wr_addr, bus.wr_data});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (m_state == 0) begin
                if (start) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            end else if (m_state == 1) begin
                if (halt_req || m_cnt == MAX_CYCLES - 1) m_state = 2;
                else m_cnt++;
            end
        end
    endtask

    task automatic compare_model();
        ent_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("trc_valid", bus.trc_valid, m_q.size() > 0);
        check("trc_ts",    bus.trc_ts,    h.ts);
        check("trc_addr",  bus.trc_addr,  h.addr);
        check("trc_data",  bus.trc_data,  h.data);
        check("running",   running,       m_state == 1);
        check("done",      done,          m_state == 2);
        check("overflow",  overflow,      m_ovf);
        check("drop_cnt",  drop_cnt,      m_drop);
        check("dbg_data",  dbg_data,      m_dbg);
    endtask

    task automatic set_in(input logic s, input logic c, input logic h, input logic we,
                          input logic [4:0] a, input logic [31:0] d,
                          input logic [4:0] da, input logic rdy);
        start = s; clear = c; halt_req = h;
        bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
        dbg_addr = da; bus.trc_ready = rdy;
    endtask

    // one clock: record accepted heads, advance the model, compare after the edge
    task automatic cycle();
        if (collect && bus.trc_valid && bus.trc_ready) got.push_back(bus.trc_ts);
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.trc_valid, 0);
        check({tag, "_ts"},    bus.trc_ts,    0);
        check({tag, "_addr"},  bus.trc_addr,  0);
        check({tag, "_data"},  bus.trc_data,  0);
        check({tag, "_dbg"},   dbg_data,      0);
        check({tag, "_run"},   running,       0);
        check({tag, "_done"},  done,          0);
        check({tag, "_ovf"},   overflow,      0);
        check({tag, "_drop"},  drop_cnt,      0);
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // directed table: start, r3=5, r3=5 (filtered), r0=9 (ignored), drain
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,5'd0,1'b0, 1'b0,16'd0,5'd0,32'd0,1'b1,32'd0};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,5'd0,1'b0, 1'b0,16'd0,5'd0,32'd0,1'b1,32'd0};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b1,5'd3,32'd5,5'd0,1'b0, 1'b1,16'd1,5'd3,32'd5,1'b1,32'd0};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b1,5'd3,32'd5,5'd3,1'b0, 1'b1,16'd1,5'd3,32'd5,1'b1,32'd5};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b1,5'd0,32'd9,5'd0,1'b0, 1'b1,16'd1,5'd3,32'd5,1'b1,32'd0};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,5'd3,1'b1, 1'b0,16'd0,5'd0,32'd0,1'b1,32'd5};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,5'd0,1'b0, 1'b0,16'd0,5'd0,32'd0,1'b1,32'd0};
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].start, tbl[i].clr, tbl[i].halt, tbl[i].wr_en,
                   tbl[i].wr_addr, tbl[i].wr_data, tbl[i].dbg, tbl[i].ready);
            cycle();
            check("tbl_valid", bus.trc_valid, tbl[i].e_valid);
            check("tbl_ts",    bus.trc_ts,    tbl[i].e_ts);
            check("tbl_addr",  bus.trc_addr,  tbl[i].e_addr);
            check("tbl_data",  bus.trc_data,  tbl[i].e_data);
            check("tbl_run",   running,       tbl[i].e_running);
            check("tbl_dbg",   dbg_data,      tbl[i].e_dbg);
        end

        // capture window: write every cycle, drain continuously
        set_in(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 1); cycle();
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 1); cycle();
        collect = 1'b1;
        for (int k = 0; k < 55; k++) begin
            set_in(0, 0, 0, 1, 5'(1 + k % 31), 32'h1000_0000 + 32'(k), 5'd0, 1);
            cycle();
            if (k == 49) check("win_done", done, 1);
        end
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 1);
        cycle();
        collect = 1'b0;
        check("win_count", got.size(), 50);
        for (int i = 0; i < got.size(); i++) check("win_ts", got[i], i);

        // overflow: 20 writes with no consumer, then full push+pop
        set_in(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        for (int k = 0; k < 20; k++) begin
            set_in(0, 0, 0, 1, 5'(1 + k), 32'hA000_0000 + 32'(k), 5'd0, 0);
            cycle();
        end
        check("ovf_drop", drop_cnt, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_oldest", bus.trc_ts, 0);
        set_in(0, 0, 0, 1, 5'd25, 32'hB000_0000, 5'd0, 1); cycle();
        check("ovf_pushpop_drop", drop_cnt, 4);
        check("ovf_pushpop_head", bus.trc_ts, 1);

        // halt at counter 7 with a write in the same cycle
        set_in(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0);
        repeat (7) cycle();
        set_in(0, 0, 1, 1, 5'd5, 32'hC0DE_0007, 5'd0, 0); cycle();
        check("halt_done", done, 1);
        check("halt_ts", bus.trc_ts, 7);
        set_in(0, 0, 0, 1, 5'd6, 32'hC0DE_0008, 5'd6, 0); cycle();
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd6, 0); cycle();
        check("halt_shadow", dbg_data, 32'hC0DE_0008);

        // clear in HALTED with 5 queued entries, then start/clear collision
        set_in(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 1, 5'(10 + k), 32'hD000_0000 + 32'(k), 5'd0, 0);
            cycle();
        end
        set_in(0, 0, 1, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(0, 1, 0, 0, 5'd0, 32'd0, 5'd12, 0); cycle();
        check("clr_valid", bus.trc_valid, 0);
        check("clr_done", done, 0);
        check("clr_shadow", dbg_data, 32'hD000_0002);
        set_in(1, 1, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        check("collide_run", running, 0);

        // asynchronous reset mid-run with FIFO half full
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        for (int k = 0; k < 8; k++) begin
            set_in(0, 0, 0, 1, 5'(1 + k), 32'hE000_0000 + 32'(k), 5'(1 + k), 0);
            cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("areset");
        model_reset();
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_in(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 0); cycle();
        set_in(0, 0, 0, 1, 5'd4, 32'h0000_0044, 5'd0, 0); cycle();
        check("restart_ts", bus.trc_ts, 0);
        check("restart_valid", bus.trc_valid, 1);

        // randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                   ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                   5'($urandom_range(0, 7)), d, 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
